serial_subtractor: RTL and testbench

- Bit-serial N-bit subtractor computing diff = a - b, LSB first, one bit per clock.
- Built around a one-bit full-subtractor cell and a registered borrow.
- Takes operands through a start/in_ready handshake.
- Returns diff and final borrow through an out_valid/out_ready handshake.
- Acts as the multi-bit sequential consumer of the one-bit half-subtractor logic, and feeds the ALU result path.

---
 rtl/serial_subtractor_pkg.sv | 13 +
 rtl/serial_subtractor_if.sv | 42 ++++
 rtl/fullsubtractor_cell.sv | 24 ++
 rtl/serial_subtractor.sv | 136 +++++++++++++
 tb/tb_serial_subtractor.sv | 188 ++++++++++++++++++
 5 files changed

// File: rtl/serial_subtractor_pkg.sv
// serial_subtractor_pkg: shared FSM state encoding and default width for the
// bit-serial subtractor slice.
package serial_subtractor_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_DONE  = 2'd2
   } state_t;

   localparam int DEFAULT_WIDTH = 8;

endpackage

// File: rtl/serial_subtractor_if.sv
// serial_subtractor_if: operand request (start/in_ready) and result
// (out_valid/out_ready) handshakes of the serial subtractor.
// Optional macro SERIAL_SUBTRACTOR_OVF_EN adds the signed-overflow flag ovf.
interface serial_subtractor_if
   import serial_subtractor_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
);
   logic             start;
   logic             in_ready;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             busy;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] diff;
   logic             bout;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
   logic             ovf;

   modport master (
      output start, a, b, out_ready,
      input  in_ready, busy, out_valid, diff, bout, ovf
   );

   modport slave (
      input  start, a, b, out_ready,
      output in_ready, busy, out_valid, diff, bout, ovf
   );
`else
   modport master (
      output start, a, b, out_ready,
      input  in_ready, busy, out_valid, diff, bout
   );

   modport slave (
      input  start, a, b, out_ready,
      output in_ready, busy, out_valid, diff, bout
   );
`endif

endinterface

// File: rtl/fullsubtractor_cell.sv
// fullsubtractor_cell: one-bit full subtractor, d = a - b - bin, built from two
// half-subtractor stages whose borrows are ORed.
module fullsubtractor_cell (
   input  logic a,
   input  logic b,
   input  logic bin,
   output logic d,
   output logic bout
);
   logic d1;
   logic b1;
   logic b2;

   // first half-subtractor: a - b
   assign d1 = a ^ b;
   assign b1 = ~a & b;

   // second half-subtractor: (a - b) - bin
   assign d  = d1 ^ bin;
   assign b2 = ~d1 & bin;

   assign bout = b1 | b2;

endmodule

// File: rtl/serial_subtractor.sv
// serial_subtractor: bit-serial diff = a - b, LSB first, one bit per clock,
// using a single fullsubtractor_cell and a registered borrow.
// Optional macro SERIAL_SUBTRACTOR_OVF_EN adds a registered signed-overflow
// flag (ovf) on the result interface.
module serial_subtractor
   import serial_subtractor_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH,
   parameter int CNT_W = $clog2(WIDTH)
) (
   input logic                clk,
   input logic                rst_n,
   serial_subtractor_if.slave bus
);
   state_t             state;
   state_t             state_nxt;
   logic [WIDTH-1:0]   a_sr;
   logic [WIDTH-1:0]   b_sr;
   logic [WIDTH-2:0]   res;
   logic [WIDTH-1:0]   diff_q;
   logic               br;
   logic               bout_q;
   logic [CNT_W-1:0]   count;
   logic               cell_d;
   logic               cell_b;
   logic               accept;
   logic               last;
   logic               retire;

   fullsubtractor_cell u_cell (
      .a    (a_sr[0]),
      .b    (b_sr[0]),
      .bin  (br),
      .d    (cell_d),
      .bout (cell_b)
   );

   assign accept = (state == ST_IDLE) && bus.start;
   assign last   = (state == ST_SHIFT) && (count == CNT_W'(WIDTH - 1));
   assign retire = (state == ST_DONE) && bus.out_ready;

   // state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // next-state logic
   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE:  if (accept) state_nxt = ST_SHIFT;
         ST_SHIFT: if (last)   state_nxt = ST_DONE;
         ST_DONE:  if (retire) state_nxt = ST_IDLE;
         default:  state_nxt = ST_IDLE;
      endcase
   end

   // handshake outputs decoded from state
   always_comb begin
      bus.in_ready  = 1'b0;
      bus.busy      = 1'b0;
      bus.out_valid = 1'b0;
      case (state)
         ST_IDLE:  bus.in_ready  = 1'b1;
         ST_SHIFT: bus.busy      = 1'b1;
         ST_DONE:  bus.out_valid = 1'b1;
         default:  bus.in_ready  = 1'b0;
      endcase
   end

   // operand shifters, borrow, bit counter and result capture
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_sr   <= '0;
         b_sr   <= '0;
         res    <= '0;
         br     <= 1'b0;
         count  <= '0;
         diff_q <= '0;
         bout_q <= 1'b0;
      end else if (accept) begin
         a_sr  <= bus.a;
         b_sr  <= bus.b;
         br    <= 1'b0;
         count <= '0;
      end else if (state == ST_SHIFT) begin
         // res keeps only the WIDTH-1 most recent bits; the current bit is
         // prepended directly when diff is captured
         res  <= (WIDTH-1)'({cell_d, res} >> 1);
         a_sr <= a_sr >> 1;
         b_sr <= b_sr >> 1;
         br   <= cell_b;
         if (last) begin
            diff_q <= {cell_d, res};
            bout_q <= cell_b;
         end else begin
            count <= count + CNT_W'(1);
         end
      end
   end

   assign bus.diff = diff_q;
   assign bus.bout = bout_q;

`ifdef SERIAL_SUBTRACTOR_OVF_EN
   logic a_msb_q;
   logic b_msb_q;
   logic ovf_q;

   // operand sign bits captured at acceptance; ovf loaded with diff, cleared on retire
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_msb_q <= 1'b0;
         b_msb_q <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         if (accept) begin
            a_msb_q <= bus.a[WIDTH-1];
            b_msb_q <= bus.b[WIDTH-1];
         end
         if (last) begin
            ovf_q <= (a_msb_q ^ b_msb_q) & (a_msb_q ^ cell_d);
         end else if (retire) begin
            ovf_q <= 1'b0;
         end
      end
   end

   assign bus.ovf = ovf_q;
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
// tb_serial_subtractor: table-driven directed vectors, protocol/reset corner
// sequences and randomized operations against an arithmetic reference model.
// Define SERIAL_SUBTRACTOR_OVF_EN to also check the ovf flag.
module tb_serial_subtractor;
   localparam int W = 8;

   logic clk = 1'b0;
   logic rst_n;

   always #5 clk = ~clk;

   serial_subtractor_if #(.WIDTH(W)) bus ();

   serial_subtractor #(.WIDTH(W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   int total = 0;
   int bad   = 0;

   typedef struct {
      logic [7:0] a;
      logic [7:0] b;
      logic [7:0] d;
      logic       bo;
      logic       ov;
      int         hold;
   } vec_t;

   vec_t vecs[9];

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h at %0t", name, got, exp, $time);
      end
   endtask

   task automatic check_ovf(input string name, input logic exp);
`ifdef SERIAL_SUBTRACTOR_OVF_EN
      check(name, 32'(bus.ovf), 32'(exp));
`else
      if (exp === 1'bz) $display("unreachable %s", name);
`endif
   endtask

   // reference: plain integer arithmetic on unsigned and signed views
   function automatic void model(input logic [7:0] a, input logic [7:0] b,
                                 output logic [7:0] d, output logic bo, output logic ov);
      int ua, ub, sa, sb, sr;
      ua = int'(a);
      ub = int'(b);
      sa = (ua >= 128) ? ua - 256 : ua;
      sb = (ub >= 128) ? ub - 256 : ub;
      d  = 8'((ua - ub + 256) % 256);
      bo = (ua < ub);
      sr = sa - sb;
      ov = (sr > 127) || (sr < -128);
   endfunction

   task automatic run_op(input logic [7:0] a, input logic [7:0] b,
                         input logic [7:0] ed, input logic eb, input logic eo,
                         input int hold, input bit inject, input string tag);
      int n = 0;
      @(negedge clk);
      check({tag, ":in_ready_idle"}, 32'(bus.in_ready), 32'd1);
      bus.out_ready = (hold == 0);
      bus.start = 1'b1;
      bus.a     = a;
      bus.b     = b;
      @(negedge clk);
      bus.start = 1'b0;
      bus.a     = 8'($urandom);
      bus.b     = 8'($urandom);
      check({tag, ":in_ready_drop"}, 32'(bus.in_ready), 32'd0);
      check({tag, ":busy"}, 32'(bus.busy), 32'd1);
      while (!bus.out_valid && n < 40) begin
         @(negedge clk);
         n++;
         if (inject && n == 3) begin
            bus.start = 1'b1;
            bus.a     = 8'h01;
            bus.b     = 8'h01;
         end
         if (inject && n == 4) bus.start = 1'b0;
      end
      check({tag, ":latency"}, 32'(n), 32'(W));
      check({tag, ":diff"}, 32'(bus.diff), 32'(ed));
      check({tag, ":bout"}, 32'(bus.bout), 32'(eb));
      check_ovf({tag, ":ovf"}, eo);
      for (int i = 0; i < hold; i++) begin
         @(negedge clk);
         check({tag, ":hold_valid"}, 32'(bus.out_valid), 32'd1);
         check({tag, ":hold_diff"}, 32'(bus.diff), 32'(ed));
      end
      bus.out_ready = 1'b1;
      @(negedge clk);
      check({tag, ":retired"}, 32'(bus.out_valid), 32'd0);
      check({tag, ":back_idle"}, 32'(bus.in_ready), 32'd1);
      check({tag, ":not_busy"}, 32'(bus.busy), 32'd0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog timeout");
      $display("test done: total=%0d bad=%0d", total, bad + 1);
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0] ra, rb, rd;
      logic       rbo, rov;

      bus.start     = 1'b0;
      bus.a         = '0;
      bus.b         = '0;
      bus.out_ready = 1'b1;
      rst_n         = 1'b0;

      vecs[0] = '{8'h5A, 8'h3C, 8'h1E, 1'b0, 1'b0, 0};
      vecs[1] = '{8'h00, 8'h01, 8'hFF, 1'b1, 1'b0, 0};
      vecs[2] = '{8'h10, 8'hFF, 8'h11, 1'b1, 1'b0, 2};
      vecs[3] = '{8'hA5, 8'hA5, 8'h00, 1'b0, 1'b0, 0};
      vecs[4] = '{8'hFF, 8'h00, 8'hFF, 1'b0, 1'b0, 1};
      vecs[5] = '{8'h80, 8'h01, 8'h7F, 1'b0, 1'b1, 0};
      vecs[6] = '{8'h05, 8'h03, 8'h02, 1'b0, 1'b0, 0};
      vecs[7] = '{8'h7F, 8'hFF, 8'h80, 1'b1, 1'b1, 0};
      vecs[8] = '{8'h09, 8'h03, 8'h06, 1'b0, 1'b0, 3};

      repeat (2) @(negedge clk);
      check("rst:in_ready", 32'(bus.in_ready), 32'd1);
      check("rst:busy", 32'(bus.busy), 32'd0);
      check("rst:out_valid", 32'(bus.out_valid), 32'd0);
      check("rst:diff", 32'(bus.diff), 32'd0);
      check("rst:bout", 32'(bus.bout), 32'd0);
      check_ovf("rst:ovf", 1'b0);
      rst_n = 1'b1;

      for (int i = 0; i < 9; i++) begin
         run_op(vecs[i].a, vecs[i].b, vecs[i].d, vecs[i].bo, vecs[i].ov,
                vecs[i].hold, 1'b0, $sformatf("vec%0d", i));
      end

      // start pulsed mid-SHIFT must be ignored
      run_op(8'h80, 8'h01, 8'h7F, 1'b0, 1'b1, 0, 1'b1, "ignore_start");

      // backpressure: out_ready low for 5 cycles in DONE
      run_op(8'h5A, 8'h3C, 8'h1E, 1'b0, 1'b0, 5, 1'b0, "backpressure");

      // asynchronous reset in the middle of SHIFT
      @(negedge clk);
      bus.out_ready = 1'b1;
      bus.start = 1'b1;
      bus.a     = 8'h80;
      bus.b     = 8'h01;
      @(negedge clk);
      bus.start = 1'b0;
      check("midrst:busy_before", 32'(bus.busy), 32'd1);
      repeat (3) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("midrst:in_ready", 32'(bus.in_ready), 32'd1);
      check("midrst:busy", 32'(bus.busy), 32'd0);
      check("midrst:out_valid", 32'(bus.out_valid), 32'd0);
      check("midrst:diff", 32'(bus.diff), 32'd0);
      check("midrst:bout", 32'(bus.bout), 32'd0);
      check_ovf("midrst:ovf", 1'b0);
      @(negedge clk);
      rst_n = 1'b1;
      run_op(8'h09, 8'h03, 8'h06, 1'b0, 1'b0, 0, 1'b0, "post_reset");

      // randomized operations against the arithmetic model
      for (int i = 0; i < 20; i++) begin
         ra = 8'($urandom_range(0, 255));
         rb = 8'($urandom_range(0, 255));
         model(ra, rb, rd, rbo, rov);
         run_op(ra, rb, rd, rbo, rov, int'($urandom_range(0, 3)), 1'b0,
                $sformatf("rnd%0d_%02h_%02h", i, ra, rb));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
